decoder_scan: RTL and testbench

//   Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with enable and two modes.

---
 rtl/decoder_scan_pkg.sv | 6 +
 rtl/dwell_counter.sv | 22 ++
 rtl/decoder_scan.sv | 58 +++++
 tb/tb_decoder_scan.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// decoder_scan_pkg: shared state encodings and mode constants for the scanning decoder.
package decoder_scan_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN} state_t;
   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN = 1'b1;
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts 0..limit; limit is resampled from dwell on every clear or reload.
module dwell_counter #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic [DWELL_W-1:0] dwell,
   output logic               tc
);
   logic [DWELL_W-1:0] cnt, lim;
   assign tc = cnt == lim;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         lim <= '0;
      end else if (clr || tc) begin
         cnt <= '0;
         lim <= dwell;
      end else
         cnt <= cnt + 1'b1;
endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with DIRECT index load and SCAN walking-one modes.
module decoder_scan
   import decoder_scan_pkg::*;
#(
   parameter int SEL_W = 2,
   parameter int DWELL_W = 8,
   parameter int ACTIVE_LOW = 0,
   localparam int N_OUT = 2**SEL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic               load,
   input  logic [SEL_W-1:0]   sel_in,
   input  logic [DWELL_W-1:0] dwell,
   output logic [N_OUT-1:0]   out,
   output logic [SEL_W-1:0]   out_idx,
   output logic               wrap
);
   localparam logic [N_OUT-1:0] INACTIVE = {N_OUT{ACTIVE_LOW != 0}};
   function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] i);
      return {{(N_OUT-1){1'b0}}, 1'b1} << i;
   endfunction
   state_t st, st_n;
   logic [SEL_W-1:0] idx_n;
   logic [N_OUT-1:0] out_n;
   logic wrap_n, clr, tc, scan, adv;
   dwell_counter #(.DWELL_W(DWELL_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .dwell(dwell),
      .tc(tc)
   );
   // The counter only runs while already scanning; any other cycle (or a load) restarts the dwell.
   always_comb begin
      scan = en && mode == MODE_SCAN;
      adv = scan && st == ST_SCAN && tc && !load;
      clr = !(scan && st == ST_SCAN) || load;
      st_n = !en ? ST_IDLE : scan ? ST_SCAN : ST_DIRECT;
      idx_n = (en && load) ? sel_in : adv ? out_idx + 1'b1 : out_idx;
      wrap_n = adv && &out_idx;
      out_n = (en ? onehot(idx_n) : '0) ^ INACTIVE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st <= ST_IDLE;
         out_idx <= '0;
         out <= INACTIVE;
         wrap <= 1'b0;
      end else begin
         st <= st_n;
         out_idx <= idx_n;
         out <= out_n;
         wrap <= wrap_n;
      end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: randomized bench comparing two decoder builds against a behavioural model.
module tb_decoder_scan;
   logic clk = 0, rst = 0, en = 0, mode = 0, load = 0;
   logic [2:0] sel = 0;
   logic [7:0] dwell = 0;
   logic [3:0] out0;
   logic [1:0] idx0;
   logic wrap0;
   logic [7:0] out1;
   logic [2:0] idx1;
   logic wrap1;
   int n_checks = 0, n_fail = 0;
   bit chk_on = 0;
   int m_st[2], m_idx[2], m_age[2], m_hold[2], m_wrap[2];
   int n, s;
   always #5 clk = ~clk;
   decoder_scan #(.SEL_W(2)) d0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel_in(sel[1:0]),
      .dwell(dwell), .out(out0), .out_idx(idx0), .wrap(wrap0)
   );
   decoder_scan #(.SEL_W(3), .ACTIVE_LOW(1)) d1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel_in(sel),
      .dwell(dwell), .out(out1), .out_idx(idx1), .wrap(wrap1)
   );
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic logic [7:0] exp_out(input int k);
      logic [7:0] v;
      v = m_st[k] != 0 ? 8'(1 << m_idx[k]) : 8'h0;
      return k != 0 ? ~v : v;
   endfunction
   // Model: each scan step shows an index for (dwell sampled at step start)+1 cycles.
   always @(posedge clk or posedge rst)
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_st[k] = 0; m_idx[k] = 0; m_age[k] = 0; m_hold[k] = 0; m_wrap[k] = 0;
         end else begin
            n = k != 0 ? 8 : 4;
            s = int'(sel) % n;
            m_wrap[k] = 0;
            if (!en) m_st[k] = 0;
            else if (!mode) begin
               m_st[k] = 1;
               if (load) m_idx[k] = s;
            end else begin
               if (load) begin
                  m_idx[k] = s; m_age[k] = 0; m_hold[k] = int'(dwell);
               end else if (m_st[k] != 2) begin
                  m_age[k] = 0; m_hold[k] = int'(dwell);
               end else if (m_age[k] == m_hold[k]) begin
                  m_wrap[k] = int'(m_idx[k] == n - 1);
                  m_idx[k] = (m_idx[k] + 1) % n;
                  m_age[k] = 0; m_hold[k] = int'(dwell);
               end else m_age[k]++;
               m_st[k] = 2;
            end
         end
      end
   always @(negedge clk)
      if (chk_on) begin
         check("out0", out0, exp_out(0));
         check("idx0", idx0, m_idx[0]);
         check("wrap0", wrap0, m_wrap[0]);
         check("out1", out1, exp_out(1));
         check("idx1", idx1, m_idx[1]);
         check("wrap1", wrap1, m_wrap[1]);
      end
   task automatic step;
      @(negedge clk);
      #1;
   endtask
   initial begin
      automatic logic [3:0] seq3[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      automatic int seq4a[4] = '{0, 0, 0, 1};
      automatic int seq4b[5] = '{1, 1, 2, 3, 0};
      #1 rst = 1;
      #2;
      check("rst out0", out0, 4'b0000);
      check("rst idx0", idx0, 0);
      check("rst wrap0", wrap0, 0);
      check("rst out1", out1, 8'hFF);
      chk_on = 1;
      step; rst = 0;
      step; step;
      check("idle out0", out0, 4'b0000);
      en = 1; mode = 0; load = 1; sel = 2;
      step;
      check("direct out0", out0, 4'b0100);
      check("direct idx0", idx0, 2);
      check("direct out1", out1, 8'hFB);
      load = 0; sel = 1;
      step;
      check("hold out0", out0, 4'b0100);
      load = 1; sel = 0;
      step;
      load = 0; mode = 1; dwell = 0;
      for (int i = 0; i < 5; i++) begin
         step;
         check("scan0 out0", out0, seq3[i]);
         check("scan0 wrap0", wrap0, i == 4);
      end
      mode = 0;
      step;
      mode = 1; dwell = 2;
      for (int i = 0; i < 4; i++) begin
         step;
         check("dwell2 idx0", idx0, seq4a[i]);
      end
      dwell = 0;
      for (int i = 0; i < 5; i++) begin
         step;
         check("dwellchg idx0", idx0, seq4b[i]);
      end
      check("dwellchg wrap0", wrap0, 1);
      dwell = 3;
      step;
      check("pre-load idx0", idx0, 1);
      load = 1; sel = 3;
      step;
      check("load out0", out0, 4'b1000);
      check("load wrap0", wrap0, 0);
      load = 0;
      for (int i = 0; i < 3; i++) begin
         step;
         check("load dwell out0", out0, 4'b1000);
      end
      step;
      check("load wrap idx0", idx0, 0);
      check("load wrap wrap0", wrap0, 1);
      en = 0; load = 1; sel = 2;
      step;
      check("en0 out0", out0, 4'b0000);
      check("en0 idx0", idx0, 0);
      check("en0 out1", out1, 8'hFF);
      en = 1; mode = 1; dwell = 0; load = 0;
      step; step;
      #2 rst = 1;
      #1;
      check("async out0", out0, 4'b0000);
      check("async idx0", idx0, 0);
      check("async out1", out1, 8'hFF);
      step; rst = 0;
      repeat (3000) begin
         step;
         rst = 0;
         en = $urandom_range(0, 99) > 7;
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         load = $urandom_range(0, 6) == 0;
         sel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) dwell = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1;
            #1;
            check("rand async out0", out0, 4'b0000);
            check("rand async out1", out1, 8'hFF);
         end
      end
      step;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
